// File: rtl/priority_scanner.sv
// Sequential priority scanner: captures a LEN-bit request word, then streams
// the index of each set bit (MSB-first or LSB-first), one per accepted beat.
module priority_scanner #(
    parameter  int LEN   = 8,
    localparam int IDX_W = $clog2(LEN),
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [LEN-1:0]   i_data,
    input  logic             i_lsb_first,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic             o_none,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     mask_q, mask_d;
    logic               dir_q, dir_d;
    logic               none_q, none_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [IDX_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   pop_in;
    logic               mask_le1;

    // Later matches overwrite earlier ones, so the iteration order sets the priority.
    always_comb begin
        sel_idx = '0;
        if (dir_q) begin
            for (int unsigned i = 0; i < LEN; i++) begin
                if (mask_q[LEN-1-i]) sel_idx = IDX_W'(LEN - 1 - i);
            end
        end else begin
            for (int unsigned i = 0; i < LEN; i++) begin
                if (mask_q[i]) sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pop_in = '0;
        for (int unsigned i = 0; i < LEN; i++) begin
            pop_in = pop_in + CNT_W'(i_data[i]);
        end
    end

    assign mask_le1 = ((mask_q & (mask_q - LEN'(1))) == '0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dir_d   = dir_q;
        none_d  = none_q;
        count_d = count_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_idx   = '0;
        o_last  = 1'b0;
        o_none  = none_q;
        o_count = count_q;
        case (state_q)
            IDLE: begin
                o_ready = ~i_rst;
                if (i_valid) begin
                    mask_d  = i_data;
                    dir_d   = i_lsb_first;
                    none_d  = (i_data == '0);
                    count_d = pop_in;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                o_valid = 1'b1;
                o_idx   = none_q ? '0 : sel_idx;
                o_last  = mask_le1 | none_q;
                if (i_valid && i_ready) begin
                    mask_d = mask_q & ~(LEN'(1) << sel_idx);
                    if (o_last) begin
                        none_d  = 1'b0;
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dir_q   <= 1'b0;
            none_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            none_q  <= none_d;
            count_q <= count_d;
        end
    end

endmodule
